// File: rtl/reg_bank_writer_pkg.sv
// Shared constants for the 32-entry register bank writer: FSM encoding,
// register count and the hardwired zero-register index.
package reg_bank_writer_pkg;

  localparam int unsigned NUM_REGS = 32;
  localparam logic [4:0]  ZERO_REG = 5'd31;
  localparam logic [4:0]  LAST_SWEEP_REG = 5'd30;

  typedef logic [0:0] state_t;
  localparam state_t IDLE  = 1'b0;
  localparam state_t SWEEP = 1'b1;

endpackage

// File: rtl/reg_bank_writer_decoder.sv
// 5-to-32 one-hot write strobe decoder, shared by host writes and the clear sweep.
module Decoder5to32 (
  input  logic [4:0]  addr_i,
  input  logic        en_i,
  output logic [31:0] strobe_o
);

  always_comb begin
    strobe_o = '0;
    if (en_i) strobe_o[addr_i] = 1'b1;
  end

endmodule

// File: rtl/reg_bank_writer.sv
// 32 x N register bank with single-port write, hardwired-zero register 31,
// and a sequential clear sweep of registers 0..30.
module reg_bank_writer
  import reg_bank_writer_pkg::*;
#(
  parameter int unsigned N = 64
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              WE,
  input  logic [4:0]        WA,
  input  logic [N-1:0]      WD,
  input  logic              CLR,
  output logic              BUSY,
  output logic              WACK,
  output logic [32*N-1:0]   Q
);

  state_t       state_q, state_d;
  logic [4:0]   cnt_q, cnt_d;
  logic         wack_q, wack_d;
  logic [N-1:0] regs_q [NUM_REGS-1];

  logic [4:0]   dec_addr;
  logic         dec_en;
  logic [N-1:0] wdata;
  logic [31:0]  strobe;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wack_d   = 1'b0;
    dec_addr = WA;
    dec_en   = 1'b0;
    wdata    = '0;
    if (state_q == SWEEP) begin
      // Sweep borrows the write decoder; host WE/CLR are ignored here.
      dec_addr = cnt_q;
      dec_en   = 1'b1;
      if (cnt_q == LAST_SWEEP_REG) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 5'd1;
      end
    end else if (CLR) begin
      state_d = SWEEP;
      cnt_d   = '0;
    end else if (WE) begin
      wack_d = 1'b1;
      dec_en = (WA != ZERO_REG);
      wdata  = WD;
    end
  end

  Decoder5to32 u_dec (
    .addr_i   (dec_addr),
    .en_i     (dec_en),
    .strobe_o (strobe)
  );

  logic unused_strobe31;
  assign unused_strobe31 = strobe[31];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wack_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wack_q  <= wack_d;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int unsigned k = 0; k < NUM_REGS - 1; k++) regs_q[k] <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_REGS - 1; k++) begin
        if (strobe[k]) regs_q[k] <= wdata;
      end
    end
  end

  assign BUSY = (state_q == SWEEP);
  assign WACK = wack_q;

  always_comb begin
    Q = '0;
    for (int unsigned k = 0; k < NUM_REGS - 1; k++) Q[k*N +: N] = regs_q[k];
  end

endmodule

// File: tb/tb_reg_bank_writer.sv
// Scoreboard bench for reg_bank_writer: driver steps a behavioural model and
// queues the expected outputs; an independent monitor compares each cycle.
module tb_reg_bank_writer;

  localparam int N = 64;

  typedef struct packed {
    logic            wack;
    logic            busy;
    logic [32*N-1:0] q;
  } exp_t;

  logic            CLK = 1'b0;
  logic            RST_N;
  logic            WE;
  logic [4:0]      WA;
  logic [N-1:0]    WD;
  logic            CLR;
  logic            BUSY;
  logic            WACK;
  logic [32*N-1:0] Q;

  reg_bank_writer #(.N(N)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .WE    (WE),
    .WA    (WA),
    .WD    (WD),
    .CLR   (CLR),
    .BUSY  (BUSY),
    .WACK  (WACK),
    .Q     (Q)
  );

  always #5 CLK = ~CLK;

  exp_t         expq[$];
  int           checks = 0;
  int           errors = 0;

  logic [N-1:0] model [32];
  int           busy_left;
  int           sweep_idx;
  bit           model_wack;

  task automatic model_reset();
    for (int k = 0; k < 32; k++) model[k] = '0;
    busy_left  = 0;
    sweep_idx  = 0;
    model_wack = 1'b0;
  endtask

  task automatic model_step(input bit rstn, input bit we, input logic [4:0] wa,
                            input logic [N-1:0] wd, input bit clr);
    model_wack = 1'b0;
    if (!rstn) begin
      model_reset();
    end else if (busy_left > 0) begin
      model[sweep_idx] = '0;
      sweep_idx++;
      busy_left--;
    end else if (clr) begin
      busy_left = 31;
      sweep_idx = 0;
    end else if (we) begin
      if (wa != 5'd31) model[wa] = wd;
      model_wack = 1'b1;
    end
  endtask

  function automatic exp_t snapshot();
    exp_t e;
    e.wack = model_wack;
    e.busy = (busy_left > 0);
    e.q    = '0;
    for (int k = 0; k < 31; k++) e.q[k*N +: N] = model[k];
    return e;
  endfunction

  task automatic compare(input string tag, input exp_t e);
    checks++;
    if (WACK !== e.wack) begin
      errors++;
      $display("FAIL %s wack: got %b want %b at %0t", tag, WACK, e.wack, $time);
    end
    checks++;
    if (BUSY !== e.busy) begin
      errors++;
      $display("FAIL %s busy: got %b want %b at %0t", tag, BUSY, e.busy, $time);
    end
    checks++;
    if (Q !== e.q) begin
      int bad;
      bad = 0;
      for (int k = 31; k >= 0; k--) if (Q[k*N +: N] !== e.q[k*N +: N]) bad = k;
      errors++;
      $display("FAIL %s q slice %0d: got %h want %h at %0t", tag, bad,
               Q[bad*N +: N], e.q[bad*N +: N], $time);
    end
  endtask

  task automatic cycle(input bit rstn, input bit we, input logic [4:0] wa,
                       input logic [N-1:0] wd, input bit clr);
    @(negedge CLK);
    RST_N = rstn;
    WE    = we;
    WA    = wa;
    WD    = wd;
    CLR   = clr;
    model_step(rstn, we, wa, wd, clr);
    expq.push_back(snapshot());
  endtask

  task automatic drive(input bit we, input logic [4:0] wa, input logic [N-1:0] wd,
                       input bit clr);
    cycle(1'b1, we, wa, wd, clr);
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, '0, 1'b0);
  endtask

  task automatic drain_sweep();
    int guard;
    guard = 0;
    while (busy_left > 0 && guard < 40) begin
      idle();
      guard++;
    end
  endtask

  task automatic load_all();
    for (int k = 0; k < 31; k++) drive(1'b1, 5'(k), N'(k + 1), 1'b0);
  endtask

  task automatic async_reset();
    @(negedge CLK);
    WE  = 1'b0;
    CLR = 1'b0;
    #2 RST_N = 1'b0;
    model_reset();
    #1 compare("async_reset", snapshot());
  endtask

  // Monitor: one expectation per clock, sampled just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        compare("cycle", e);
      end
    end
  end

  initial begin
    int guard;
    RST_N = 1'b0;
    WE    = 1'b0;
    WA    = '0;
    WD    = '0;
    CLR   = 1'b0;
    model_reset();
    repeat (2) @(negedge CLK);
    compare("reset", snapshot());

    // Single write then zero-register write.
    drive(1'b1, 5'd5, N'(64'h1234), 1'b0);
    idle();
    drive(1'b1, 5'd31, N'(64'hFFFF), 1'b0);
    idle();

    // Full load and sweep.
    load_all();
    drive(1'b0, 5'd0, '0, 1'b1);
    drain_sweep();
    idle();

    // CLR and WE on the same edge: write is dropped.
    load_all();
    drive(1'b1, 5'd3, N'(64'hAA), 1'b1);
    drain_sweep();
    idle();

    // Writes and CLR during a sweep are ignored; write succeeds afterward.
    drive(1'b0, 5'd0, '0, 1'b1);
    drive(1'b1, 5'd7, N'(64'h77), 1'b0);
    drive(1'b0, 5'd0, '0, 1'b1);
    drain_sweep();
    drive(1'b1, 5'd7, N'(64'h77), 1'b0);
    idle();

    // Reset mid-sweep, then write on the first edge after release.
    load_all();
    drive(1'b0, 5'd0, '0, 1'b1);
    repeat (10) idle();
    async_reset();
    cycle(1'b0, 1'b0, 5'd0, '0, 1'b0);
    cycle(1'b1, 1'b1, 5'd2, N'(64'h55), 1'b0);
    idle();

    // Randomized traffic, including stray WE/CLR during sweeps.
    for (int i = 0; i < 500; i++) begin
      drive($urandom_range(0, 2) != 0, 5'($urandom_range(0, 31)),
            {$urandom, $urandom}, $urandom_range(0, 49) == 0);
    end
    drain_sweep();
    idle();

    guard = 0;
    while (expq.size() > 0 && guard < 10) begin
      @(posedge CLK);
      guard++;
    end
    #2;
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", expq.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_bank_writer.md
REG_BANK_WRITER -- requirements
Module: reg_bank_writer

Interface
REQ-001 Parameter: N, default 64, data width of each register in bits.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RST_N  input  1  reset, asynchronous, active-low.
REQ-004 WE  input  1  write enable, sampled on rising CLK.
REQ-005 WA  input  5  write address, 0..31.
REQ-006 WD  input  N  write data.
REQ-007 CLR  input  1  request to clear registers 0..30 by sequential sweep.
REQ-008 BUSY  output  1  high while a clear sweep is in progress.
REQ-009 WACK  output  1  one-cycle pulse acknowledging an accepted write.
REQ-010 Q  output  32*N  flat register contents; register k occupies bits [k*N+N-1 : k*N]; feeds the 32-input read mux.

Function
REQ-011 Storage SHALL be 32 registers of N bits; register 31 SHALL read as all-zero at all times (XZR), with no flops required for it.
REQ-012 FSM SHALL have two states: IDLE and SWEEP.
REQ-013 In IDLE, with WE=1, CLR=0, WA!=31: reg[WA] <= WD at the edge; Q reflects the new value the same edge (no extra latency); WACK=1 for the following cycle only.
REQ-014 In IDLE, with WE=1 and WA=31: no register changes and WACK SHALL still pulse (write accepted, discarded).
REQ-015 Only one register SHALL change per write; all other registers hold.
REQ-016 In IDLE, with CLR=1: transition to SWEEP, sweep counter <= 0, BUSY=1 from the next cycle; a simultaneous WE SHALL be dropped (no write, no WACK).
REQ-017 In SWEEP: each cycle reg[cnt] <= 0 and cnt <= cnt+1; after register 30 is cleared, return to IDLE; BUSY SHALL be high for exactly 31 cycles.
REQ-018 In SWEEP: WE and CLR SHALL be ignored (no write, no WACK, no restart); the master must hold off while BUSY=1.
REQ-019 Registers not yet reached by the sweep SHALL retain their values until their clear cycle.
REQ-020 The sweep counter SHALL be 5 bits wide and never reach 31 in SWEEP.
REQ-021 WACK and BUSY SHALL be registered outputs (glitch-free).

Reset
REQ-022 RST_N low SHALL immediately (asynchronously) force all registers to 0, state to IDLE, counter to 0, BUSY=0, WACK=0.
REQ-023 Reset asserted mid-sweep SHALL abort the sweep; after release the block SHALL be in IDLE and accept a write on the first edge.
REQ-024 Reset release SHALL be synchronized by the system; the block takes no action on the release edge itself beyond normal sampling.

Structure
REQ-025 A shared package SHALL hold the FSM state encoding (IDLE=0, SWEEP=1), the register count constant (32), and the zero-register index constant (31).
REQ-026 One sub-module SHALL be used: Decoder5to32, converting WA plus an enable into 32 one-hot write strobes; the sweep path SHALL reuse the same decoder with the counter as the address.

Verification
REQ-027 Reset, then WE=1 WA=5 WD=0x1234 -> Q slice 5 = 0x1234 after the edge, WACK high for one cycle, all other slices 0.
REQ-028 WE=1 WA=31 WD=0xFFFF -> slice 31 stays 0, WACK pulses, no other register changes.
REQ-029 Load registers 0..30 with k+1, pulse CLR -> BUSY high 31 cycles, register k reads 0 from the cycle after its sweep step, BUSY low afterward.
REQ-030 CLR=1 and WE=1 WA=3 WD=0xAA on the same edge -> sweep starts, register 3 not written to 0xAA, no WACK.
REQ-031 WE=1 WA=7 during SWEEP -> ignored, no WACK; after BUSY falls, the same write succeeds.
REQ-032 Assert RST_N low at sweep cycle 10 with registers preloaded -> all slices 0 immediately, BUSY=0; after release, WE=1 WA=2 WD=0x55 -> slice 2 = 0x55.
